// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: two-stage pipelined carry-lookahead adder/subtractor with
// valid/ready handshaking and carry-out, signed-overflow and zero flags.
//
// The carry chain is split at the word midpoint. Stage 1 adds the lower half
// and registers the carry into the upper half (cmid) together with the
// upper-half propagate/generate bits. Stage 2 finishes the upper half and
// registers the result and flags.
//
// Parameters:
//   WIDTH  operand/result width; must be a multiple of 2*GROUP
//   GROUP  bits per lookahead group
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   in_valid/in_ready  operand handshake (in_ready is combinational on out_ready)
//   a, b, cin, sub     sub=1: a + ~b + 1 (cin ignored); sub=0: a + b + cin
//   sat                saturate on signed overflow (CLA_PIPE_SAT_EN only)
//   out_valid/out_ready result handshake
//   sum, cout, ovf, zero  result, raw carry out, signed overflow, sum==0
// Optional feature macro: CLA_PIPE_SAT_EN enables signed saturation.

// One lookahead group: group propagate/generate give the group carry out;
// bit carries inside the group feed the sum bits.
module cla_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] p,
    input  logic [GROUP-1:0] g,
    input  logic             ci,
    output logic [GROUP-1:0] s,
    output logic             co
);
    logic [GROUP-1:0] c;
    logic             pg;
    logic             gg;

    always_comb begin
        c    = '0;
        c[0] = ci;
        for (int i = 1; i < GROUP; i++) begin
            c[i] = g[i-1] | (p[i-1] & c[i-1]);
        end
        pg = 1'b1;
        gg = 1'b0;
        for (int i = 0; i < GROUP; i++) begin
            gg = g[i] | (p[i] & gg);
            pg = pg & p[i];
        end
        s  = p ^ c;
        co = gg | (pg & ci);
    end
endmodule

// Half-word adder: group carries ripple group-to-group.
module cla_half #(
    parameter int W     = 8,
    parameter int GROUP = 4
) (
    input  logic [W-1:0] p,
    input  logic [W-1:0] g,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);
    localparam int NG = W / GROUP;

    logic [NG:0] gc;

    assign gc[0] = ci;
    assign co    = gc[NG];

    for (genvar i = 0; i < NG; i++) begin : g_grp
        cla_group #(.GROUP(GROUP)) u_grp (
            .p  (p[i*GROUP +: GROUP]),
            .g  (g[i*GROUP +: GROUP]),
            .ci (gc[i]),
            .s  (s[i*GROUP +: GROUP]),
            .co (gc[i+1])
        );
    end
endmodule

module cla_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int H = WIDTH / 2;

    // vld_q[1]: stage-1 occupied, vld_q[2]: stage-2 occupied (out_valid)
    logic [2:1]       vld_q, vld_d;
    logic [H-1:0]     lo_sum_q, lo_sum_d;
    logic             cmid_q, cmid_d;
    logic [H-1:0]     hi_p_q, hi_p_d;
    logic [H-1:0]     hi_g_q, hi_g_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic             s2_load, s1_load, s1_fire, s1_move;
    logic [WIDTH-1:0] bx, p1, g1;
    logic             c0;
    logic [H-1:0]     lo_sum;
    logic             cmid;
    logic [H-1:0]     hi_sum;
    logic             hi_co;
    logic [WIDTH-1:0] res;
    logic             ovf_w;

`ifdef CLA_PIPE_SAT_EN
    logic             sat_q, sat_d;
`else
    logic             unused_sat;
    assign unused_sat = sat;
`endif

    // No skid buffer: a stage accepts whenever it is empty or its content
    // leaves on the same edge.
    assign s2_load  = !vld_q[2] | out_ready;
    assign s1_load  = !vld_q[1] | s2_load;
    assign in_ready = s1_load;
    assign s1_fire  = in_valid & s1_load;
    assign s1_move  = vld_q[1] & s2_load;

    assign bx = sub ? ~b : b;
    assign c0 = sub | cin;
    assign p1 = a ^ bx;
    assign g1 = a & bx;

    cla_half #(.W(H), .GROUP(GROUP)) u_lo (
        .p  (p1[H-1:0]),
        .g  (g1[H-1:0]),
        .ci (c0),
        .s  (lo_sum),
        .co (cmid)
    );

    cla_half #(.W(H), .GROUP(GROUP)) u_hi (
        .p  (hi_p_q),
        .g  (hi_g_q),
        .ci (cmid_q),
        .s  (hi_sum),
        .co (hi_co)
    );

    // Overflow: operands agree in sign (after inversion) but the result does not.
    assign ovf_w = (sa_q == sb_q) && (hi_sum[H-1] != sa_q);

    always_comb begin
        res = {hi_sum, lo_sum_q};
`ifdef CLA_PIPE_SAT_EN
        if (sat_q && ovf_w) begin
            res = sa_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_comb begin
        vld_d    = vld_q;
        lo_sum_d = lo_sum_q;
        cmid_d   = cmid_q;
        hi_p_d   = hi_p_q;
        hi_g_d   = hi_g_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
`ifdef CLA_PIPE_SAT_EN
        sat_d    = sat_q;
`endif
        if (s1_load) vld_d[1] = in_valid;
        if (s2_load) vld_d[2] = vld_q[1];

        if (s1_fire) begin
            lo_sum_d = lo_sum;
            cmid_d   = cmid;
            hi_p_d   = p1[WIDTH-1:H];
            hi_g_d   = g1[WIDTH-1:H];
            sa_d     = a[WIDTH-1];
            sb_d     = bx[WIDTH-1];
`ifdef CLA_PIPE_SAT_EN
            sat_d    = sat;
`endif
        end

        if (s1_move) begin
            sum_d  = res;
            cout_d = hi_co;
            ovf_d  = ovf_w;
            zero_d = (res == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q    <= '0;
            lo_sum_q <= '0;
            cmid_q   <= 1'b0;
            hi_p_q   <= '0;
            hi_g_q   <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
`ifdef CLA_PIPE_SAT_EN
            sat_q    <= 1'b0;
`endif
        end else begin
            vld_q    <= vld_d;
            lo_sum_q <= lo_sum_d;
            cmid_q   <= cmid_d;
            hi_p_q   <= hi_p_d;
            hi_g_q   <= hi_g_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
`ifdef CLA_PIPE_SAT_EN
            sat_q    <= sat_d;
`endif
        end
    end

    assign out_valid = vld_q[2];
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder (WIDTH=16, GROUP=4): directed vector
// table, latency, stall/back-pressure, randomised traffic and mid-flight reset.
module tb_cla_pipe_adder;
    localparam int W = 16;
`ifdef CLA_PIPE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready;
    logic [W-1:0] a, b;
    logic         cin, sub, sat;
    logic         out_valid, out_ready;
    logic [W-1:0] sum;
    logic         cout, ovf, zero;

    cla_pipe_adder #(.WIDTH(W), .GROUP(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .sat(sat),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a, b;
        logic         cin, sub, sat;
        logic [W-1:0] s;
        logic         co, ov, z;
    } vec_t;

    typedef struct {
        logic [W-1:0] s;
        logic         co, ov, z;
        int           acc;
    } exp_t;

    exp_t  sbq[$];
    vec_t  tbl[11];
    int    errors = 0, checks = 0;
    int    cyc = 0, pushes = 0, pops = 0;
    bit    lat_chk = 1'b0;
    bit    rnd_on = 1'b0;
    bit    hold_v = 1'b0;
    logic [W+2:0] hold_w;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain wide arithmetic.
    function automatic vec_t mkvec(input logic [W-1:0] va, input logic [W-1:0] vb,
                                   input logic vcin, input logic vsub, input logic vsat);
        vec_t         v;
        logic [W-1:0] bb;
        logic [W:0]   full;
        bb     = vsub ? ~vb : vb;
        full   = {1'b0, va} + {1'b0, bb} + {{W{1'b0}}, (vsub ? 1'b1 : vcin)};
        v.a    = va; v.b = vb; v.cin = vcin; v.sub = vsub; v.sat = vsat;
        v.co   = full[W];
        v.s    = full[W-1:0];
        v.ov   = (va[W-1] == bb[W-1]) && (v.s[W-1] != va[W-1]);
        if (SAT && vsat && v.ov) v.s = va[W-1] ? 16'h8000 : 16'h7FFF;
        v.z    = (v.s == 0);
        return v;
    endfunction

    // Drive one operation (called at posedge+1); returns at posedge+1 after acceptance.
    task automatic issue(input vec_t v);
        exp_t e;
        a = v.a; b = v.b; cin = v.cin; sub = v.sub; sat = v.sat;
        in_valid = 1'b1;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (in_ready) begin
                e.s = v.s; e.co = v.co; e.ov = v.ov; e.z = v.z; e.acc = cyc;
                sbq.push_back(e);
                pushes++;
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        checks++; errors++;
        $display("FAIL issue_timeout: in_ready stuck 0, required 1");
    endtask

    // Output monitor: scoreboard pop, latency and stall-stability checks.
    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v && out_valid) chk("hold_stable", {cout, ovf, zero, sum}, hold_w);
            hold_v = out_valid && !out_ready;
            hold_w = {cout, ovf, zero, sum};
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra_output: got sum %0h, required none", sum);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    pops++;
                    chk("sum", sum, e.s);
                    chk("cout", cout, e.co);
                    chk("ovf", ovf, e.ov);
                    chk("zero", zero, e.z);
                    if (lat_chk) chk("latency", cyc - e.acc, 2);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //              a        b        cin   sub   sat   sum                     co    ov    z
        tbl[0]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h8000,               1'b0, 1'b1, 1'b0};
        tbl[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000,               1'b1, 1'b0, 1'b1};
        tbl[3]  = '{16'h00FF, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0100,               1'b0, 1'b0, 1'b0};
        tbl[4]  = '{16'h0005, 16'h0005, 1'b1, 1'b1, 1'b0, 16'h0000,               1'b1, 1'b0, 1'b1};
        tbl[5]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h7FFF,               1'b1, 1'b1, 1'b0};
        tbl[6]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, SAT ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, 16'h5555,               1'b0, 1'b0, 1'b0};
        tbl[8]  = '{16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0, 16'hFFFF,               1'b0, 1'b0, 1'b0};
        tbl[9]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0, 16'h0000,               1'b1, 1'b1, 1'b1};
        tbl[10] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1, SAT ? 16'h8000 : 16'h0000, 1'b1, 1'b1, !SAT};

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; sat = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_zero", zero, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Directed table, back-to-back, unstalled: every result at issue+2.
        lat_chk = 1'b1;
        for (int i = 0; i < 11; i++) issue(tbl[i]);
        in_valid = 1'b0;
        repeat (5) @(posedge clk); #1;
        chk("drain_tbl", sbq.size(), 0);

        // Three consecutive adds, unstalled.
        issue(mkvec(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0));
        issue(mkvec(16'h0002, 16'h0002, 1'b0, 1'b0, 1'b0));
        issue(mkvec(16'h0003, 16'h0003, 1'b0, 1'b0, 1'b0));
        in_valid = 1'b0;
        repeat (5) @(posedge clk); #1;
        chk("drain_seq", sbq.size(), 0);

        // Same three with the consumer stalled: pipe fills, in_ready drops.
        lat_chk = 1'b0;
        out_ready = 1'b0;
        fork
            begin
                issue(mkvec(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0));
                issue(mkvec(16'h0002, 16'h0002, 1'b0, 1'b0, 1'b0));
                issue(mkvec(16'h0003, 16'h0003, 1'b0, 1'b0, 1'b0));
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(negedge clk);
                chk("stall_in_ready", in_ready, 0);
                chk("stall_out_valid", out_valid, 1);
                repeat (2) begin
                    @(negedge clk);
                    chk("stall_in_ready_hold", in_ready, 0);
                end
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        repeat (6) @(posedge clk); #1;
        chk("drain_stall", sbq.size(), 0);

        // Random operands with random back-pressure and idle gaps.
        rnd_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    issue(mkvec(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom)));
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk); #1;
                    end
                end
                in_valid = 1'b0;
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        repeat (6) @(posedge clk); #1;
        chk("drain_rand", sbq.size(), 0);

        // Reset with two operations in flight: both discarded.
        issue(mkvec(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0));
        issue(mkvec(16'h0F0F, 16'h0101, 1'b0, 1'b0, 1'b0));
        in_valid = 1'b0;
        rst = 1'b1;
        chk("inflight_at_rst", sbq.size(), 2);
        sbq.delete();
        #1;
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_sum", sum, 0);
        chk("rst_mid_flags", {cout, ovf, zero}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_out_valid", out_valid, 0);
        end
        chk("pop_count", pops, pushes - 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
